wb_pipe_master: RTL and testbench

WB_PIPE_MASTER -- requirements
Module: wb_pipe_master

---
 rtl/wb_pipe_master.sv | 218 +++++++++++++++++++++
 tb/tb_wb_pipe_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_master.sv
// rtl/wb_pipe_master.sv - Wishbone pipelined bus master with request/response queues
//
// Purpose: accepts {we, sel, adr, dat} requests through a put port, issues them
// as Wishbone pipelined-mode transfers, and returns {err, data} responses in
// request order through a get port. An error or ACK timeout aborts the bus
// cycle and completes every outstanding request with an error response.
//
// Ports:
//   CLK, RST_N                        clock, asynchronous active-low reset
//   request_put, EN_request_put       request {we, sel, adr, dat} and enqueue strobe
//   RDY_request_put                   request queue can accept
//   response_get, EN_response_get     response {err, data} and dequeue strobe
//   RDY_response_get                  response queue non-empty
//   CYC_O, STB_O, WE_O                Wishbone cycle, strobe, direction
//   ADR_O, SEL_O, DAT_O               Wishbone address, byte selects, write data
//   STALL_I, ACK_I, ERR_I, DAT_I      Wishbone stall, acknowledge, error, read data

module wb_pipe_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 8,
    parameter int REQ_DEPTH = 2,
    parameter int TIMEOUT   = 0
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]     request_put,
    input  logic                                EN_request_put,
    output logic                                RDY_request_put,
    output logic [DATA_W:0]                     response_get,
    input  logic                                EN_response_get,
    output logic                                RDY_response_get,
    output logic                                CYC_O,
    output logic                                STB_O,
    output logic                                WE_O,
    output logic [ADDR_W-1:0]                   ADR_O,
    output logic [DATA_W/8-1:0]                 SEL_O,
    output logic [DATA_W-1:0]                   DAT_O,
    input  logic                                STALL_I,
    input  logic                                ACK_I,
    input  logic                                ERR_I,
    input  logic [DATA_W-1:0]                   DAT_I
);

    localparam int SEL_W = DATA_W / 8;
    localparam int REQ_W = 1 + SEL_W + ADDR_W + DATA_W;
    localparam int RSP_W = DATA_W + 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int RQ_AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int RQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int RS_AW = $clog2(MAX_OUT);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [RQ_AW-1:0] RQ_LAST  = RQ_AW'(REQ_DEPTH - 1);
    localparam logic [RQ_CW-1:0] RQ_FULL  = RQ_CW'(REQ_DEPTH);
    localparam logic [RS_AW-1:0] RS_LAST  = RS_AW'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] RS_FULL  = CNT_W'(MAX_OUT);
    localparam logic [CNT_W:0]   OUT_LIM  = (CNT_W + 1)'(MAX_OUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, ABORT} state_t;

    state_t state, state_nxt;

    // Request queue
    logic [REQ_W-1:0] rq_mem [REQ_DEPTH];
    logic [RQ_AW-1:0] rq_rd, rq_wr;
    logic [RQ_CW-1:0] rq_cnt, rq_cnt_nxt;
    logic             rq_push;

    // Response queue; sized to MAX_OUT so reserved space always fits
    logic [RSP_W-1:0] rs_mem [MAX_OUT];
    logic [RS_AW-1:0] rs_rd, rs_wr;
    logic [CNT_W-1:0] rs_cnt;
    logic             rs_push, rs_pop;
    logic [RSP_W-1:0] rs_data;

    logic [CNT_W-1:0] outstanding, out_nxt;
    logic [CNT_W:0]   in_use;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             tmo_hit;
    logic             cur_we;

    logic              head_we;
    logic [SEL_W-1:0]  head_sel;
    logic [ADDR_W-1:0] head_adr;
    logic [DATA_W-1:0] head_dat;

    logic stb, issue, bus_rsp, bus_err;

    function automatic logic [RQ_AW-1:0] rq_inc(input logic [RQ_AW-1:0] p);
        return (p == RQ_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RS_AW-1:0] rs_inc(input logic [RS_AW-1:0] p);
        return (p == RS_LAST) ? '0 : p + 1'b1;
    endfunction

    assign {head_we, head_sel, head_adr, head_dat} = rq_mem[rq_rd];

    assign rq_push = EN_request_put && (rq_cnt != RQ_FULL);
    assign rs_pop  = EN_response_get && (rs_cnt != '0);

    // Slots held by in-flight requests plus undelivered responses; issuing
    // only below MAX_OUT guarantees every future response has a queue slot.
    assign in_use = {1'b0, outstanding} + {1'b0, rs_cnt};

    // Strobe is recomputed each cycle from the unpopped head; while stalled
    // none of its inputs can make it drop except leaving BUS, so the beat holds.
    assign stb = (state == BUS) && (rq_cnt != '0) && (in_use < OUT_LIM) &&
                 ((head_we == cur_we) || (outstanding == '0));
    assign issue = stb && !STALL_I;

    // Bus terminations only count while a request is actually in flight.
    assign bus_rsp = (state == BUS) && (ACK_I || ERR_I) && (outstanding != '0);
    assign bus_err = bus_rsp && ERR_I;

    assign tmo_hit = (TIMEOUT > 0) && (state == BUS) && (outstanding != '0) &&
                     !ACK_I && !ERR_I && (tmo_cnt == TMO_LAST);

    always_comb begin
        tmo_nxt = '0;
        if ((TIMEOUT > 0) && (state == BUS) && (outstanding != '0) &&
            !ACK_I && !ERR_I && !tmo_hit)
            tmo_nxt = tmo_cnt + 1'b1;
    end

    always_comb begin
        out_nxt = outstanding;
        if (state == ABORT) begin
            if (outstanding != '0)
                out_nxt = outstanding - 1'b1;
        end else begin
            out_nxt = outstanding + CNT_W'(issue) - CNT_W'(bus_rsp);
        end
    end

    assign rq_cnt_nxt = rq_cnt + RQ_CW'(rq_push) - RQ_CW'(issue);

    // Abort drains one synthetic error response per cycle.
    always_comb begin
        rs_push = 1'b0;
        rs_data = '0;
        if (state == ABORT) begin
            if (outstanding != '0) begin
                rs_push = 1'b1;
                rs_data = {1'b1, {DATA_W{1'b0}}};
            end
        end else if (bus_rsp) begin
            rs_push = 1'b1;
            rs_data = {ERR_I, DAT_I};
        end
        if (rs_cnt == RS_FULL)
            rs_push = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (rq_cnt != '0) state_nxt = BUS;
            BUS: begin
                if (bus_err || tmo_hit)
                    state_nxt = ABORT;
                else if ((rq_cnt_nxt == '0) && (out_nxt == '0))
                    state_nxt = IDLE;
            end
            ABORT: if (out_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            outstanding <= '0;
            tmo_cnt     <= '0;
            cur_we      <= 1'b0;
            rq_rd       <= '0;
            rq_wr       <= '0;
            rq_cnt      <= '0;
            rs_rd       <= '0;
            rs_wr       <= '0;
            rs_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            tmo_cnt     <= tmo_nxt;
            rq_cnt      <= rq_cnt_nxt;
            rs_cnt      <= rs_cnt + CNT_W'(rs_push) - CNT_W'(rs_pop);
            if (rq_push) rq_wr <= rq_inc(rq_wr);
            if (issue) begin
                rq_rd  <= rq_inc(rq_rd);
                cur_we <= head_we;
            end
            if (rs_push) rs_wr <= rs_inc(rs_wr);
            if (rs_pop)  rs_rd <= rs_inc(rs_rd);
        end
    end

    always_ff @(posedge CLK) begin
        if (rq_push) rq_mem[rq_wr] <= request_put;
        if (rs_push) rs_mem[rs_wr] <= rs_data;
    end

    assign RDY_request_put  = (rq_cnt != RQ_FULL);
    assign RDY_response_get = (rs_cnt != '0);
    assign response_get     = rs_mem[rs_rd];

    // Bus fields are zero whenever no beat is presented, which also gives
    // all-zero outputs throughout reset.
    assign CYC_O = (state == BUS);
    assign STB_O = stb;
    assign WE_O  = stb && head_we;
    assign ADR_O = stb ? head_adr : '0;
    assign DAT_O = stb ? head_dat : '0;
    assign SEL_O = !stb ? '0 : ((head_we && (head_sel == '0)) ? '1 : head_sel);

endmodule

// File: tb/tb_wb_pipe_master.sv
// tb/tb_wb_pipe_master.sv - scoreboard testbench for wb_pipe_master

module tb_wb_pipe_master;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic [68:0] request_put = '0;
    logic        EN_request_put = 1'b0;
    logic        RDY_request_put;
    logic [32:0] response_get;
    logic        EN_response_get = 1'b0;
    logic        RDY_response_get;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_O;
    logic        STALL_I = 1'b0;
    logic        ACK_I = 1'b0;
    logic        ERR_I = 1'b0;
    logic [31:0] DAT_I = '0;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q [$];
    logic [31:0] ack_data_q [$];

    bit hold_get = 1'b0;
    bit auto_ack = 1'b0;
    bit late_ack = 1'b0;
    int err_idx  = -1;
    int ack_num  = 0;
    int pend     = 0;
    int beats    = 0;

    always #5 clk = ~clk;

    wb_pipe_master #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .REQ_DEPTH(2), .TIMEOUT(16)
    ) dut (
        .CLK(clk), .RST_N(RST_N),
        .request_put(request_put), .EN_request_put(EN_request_put),
        .RDY_request_put(RDY_request_put),
        .response_get(response_get), .EN_response_get(EN_response_get),
        .RDY_response_get(RDY_response_get),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O),
        .STALL_I(STALL_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .DAT_I(DAT_I)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
        int n = 0;
        while (RDY_request_put !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("put_ready_timeout", 64'd0, 64'd1);
        request_put    = {we, sel, adr, dat};
        EN_request_put = 1'b1;
        tick();
        EN_request_put = 1'b0;
    endtask

    task automatic wait_stb();
        int n = 0;
        while (STB_O !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("stb_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats < target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("beat_timeout", 64'(beats), 64'(target));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    // Response monitor: pops the scoreboard whenever a response is offered.
    always @(negedge clk) begin
        logic [32:0] e;
        #1;
        EN_response_get = 1'b0;
        if (RST_N && RDY_response_get === 1'b1 && !hold_get) begin
            EN_response_get = 1'b1;
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(response_get), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("resp", 64'(response_get), 64'(e));
            end
        end
    end

    // Slave model: acknowledges issued beats in order, never in the issue cycle.
    always @(negedge clk) begin
        #1;
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        DAT_I = '0;
        if (!RST_N || CYC_O !== 1'b1) begin
            pend = 0;
        end else begin
            if (auto_ack && pend > 0) begin
                if (ack_num == err_idx) ERR_I = 1'b1;
                else                    ACK_I = 1'b1;
                if (ack_data_q.size() > 0) DAT_I = ack_data_q.pop_front();
                ack_num++;
                pend--;
            end
            if (STB_O === 1'b1 && STALL_I === 1'b0) begin
                pend++;
                beats++;
            end
        end
        if (late_ack) begin
            ACK_I = 1'b1;
            DAT_I = 32'hDEAD_BEEF;
        end
    end

    initial begin
        int b0;
        int bad;

        // Reset state
        repeat (2) tick();
        chk("rst_cyc", 64'(CYC_O), 64'd0);
        chk("rst_stb", 64'(STB_O), 64'd0);
        chk("rst_bus_fields", 64'({WE_O, ADR_O, SEL_O}), 64'd0);
        chk("rst_rdy_put", 64'(RDY_request_put), 64'd1);
        chk("rst_rdy_get", 64'(RDY_response_get), 64'd0);
        RST_N = 1'b1;
        tick();

        // Single read, ACK one cycle after issue
        ack_data_q.push_back(32'h0000_CAFE);
        exp_q.push_back({1'b0, 32'h0000_CAFE});
        auto_ack = 1'b1;
        put(1'b0, 4'hF, 32'h100, 32'h0);
        wait_stb();
        chk("rd_adr", 64'(ADR_O), 64'h100);
        chk("rd_sel_we", 64'({SEL_O, WE_O}), 64'h1E);
        tick();
        tick();
        chk("rd_cyc_fall", 64'(CYC_O), 64'd0);
        wait_drain();
        auto_ack = 1'b0;

        // Six pipelined reads against a window of four
        hold_get = 1'b1;
        b0 = beats;
        for (int i = 1; i <= 6; i++) put(1'b0, 4'hF, 32'(i * 16), 32'h0);
        repeat (2) tick();
        chk("pipe_stb_blocked", 64'(STB_O), 64'd0);
        chk("pipe_beats4", 64'(beats - b0), 64'd4);
        for (int i = 1; i <= 6; i++) begin
            ack_data_q.push_back(32'h1000 + 32'(i));
            exp_q.push_back({1'b0, 32'h1000 + 32'(i)});
        end
        auto_ack = 1'b1;
        repeat (8) tick();
        chk("pipe_stb_full_rsp", 64'(STB_O), 64'd0);
        chk("pipe_beats_still4", 64'(beats - b0), 64'd4);
        chk("pipe_rdy_get", 64'(RDY_response_get), 64'd1);
        hold_get = 1'b0;
        wait_drain();
        chk("pipe_beats6", 64'(beats - b0), 64'd6);

        // Stall hold on a write
        STALL_I = 1'b1;
        b0 = beats;
        ack_data_q.push_back(32'h0);
        exp_q.push_back({1'b0, 32'h0});
        put(1'b1, 4'h3, 32'h200, 32'h55AA);
        wait_stb();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({STB_O, WE_O, ADR_O, SEL_O, DAT_O} !== {1'b1, 1'b1, 32'h200, 4'h3, 32'h55AA}) bad++;
            tick();
        end
        chk("stall_hold", 64'(bad), 64'd0);
        STALL_I = 1'b0;
        wait_drain();
        chk("stall_one_issue", 64'(beats - b0), 64'd1);

        // Write with sel=0 goes out with all byte lanes
        ack_data_q.push_back(32'h0);
        exp_q.push_back({1'b0, 32'h0});
        put(1'b1, 4'h0, 32'h300, 32'h77);
        wait_stb();
        chk("sel0_all_ones", 64'(SEL_O), 64'hF);
        wait_drain();
        auto_ack = 1'b0;

        // Error abort with three in flight and a queued write behind them
        b0 = beats;
        put(1'b0, 4'hF, 32'h400, 32'h0);
        put(1'b0, 4'hF, 32'h404, 32'h0);
        put(1'b0, 4'hF, 32'h408, 32'h0);
        put(1'b1, 4'hF, 32'h500, 32'h99);
        wait_beats(b0 + 3);
        chk("err_beats3", 64'(beats - b0), 64'd3);
        ack_data_q.push_back(32'hBAD0);
        ack_data_q.push_back(32'hAB);
        exp_q.push_back({1'b1, 32'hBAD0});
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b0, 32'hAB});
        err_idx  = ack_num;
        auto_ack = 1'b1;
        tick();
        tick();
        chk("err_cyc_drop", 64'({CYC_O, STB_O}), 64'd0);
        wait_stb();
        chk("err_new_cycle_wr", 64'({WE_O, ADR_O, DAT_O}), {31'd0, 1'b1, 32'h500, 32'h99} >> 0);
        wait_drain();
        auto_ack = 1'b0;
        err_idx  = -1;

        // Timeout after 16 silent cycles, then a late ACK
        exp_q.push_back({1'b1, 32'h0});
        put(1'b0, 4'hF, 32'h600, 32'h0);
        wait_stb();
        tick();
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (CYC_O !== 1'b1) bad++;
            tick();
        end
        chk("tmo_cyc_held16", 64'(bad), 64'd0);
        chk("tmo_cyc_drop17", 64'(CYC_O), 64'd0);
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        wait_drain();
        repeat (3) tick();
        chk("tmo_late_ack_ignored", 64'(RDY_response_get), 64'd0);

        // Read then write: write beat waits for the read to complete
        put(1'b0, 4'hF, 32'h700, 32'h0);
        put(1'b1, 4'hF, 32'h704, 32'h1234);
        wait_stb();
        tick();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (STB_O !== 1'b0) bad++;
            tick();
        end
        chk("dir_wr_withheld", 64'(bad), 64'd0);
        ack_data_q.push_back(32'h77);
        ack_data_q.push_back(32'h0);
        exp_q.push_back({1'b0, 32'h77});
        exp_q.push_back({1'b0, 32'h0});
        auto_ack = 1'b1;
        wait_stb();
        chk("dir_wr_beat", 64'({WE_O, ADR_O}), {31'd0, 1'b1, 32'h704});
        wait_drain();
        auto_ack = 1'b0;

        // Reset with two requests outstanding
        b0 = beats;
        put(1'b0, 4'hF, 32'h800, 32'h0);
        put(1'b0, 4'hF, 32'h804, 32'h0);
        wait_beats(b0 + 2);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_cyc_async", 64'(CYC_O), 64'd0);
        tick();
        chk("mid_rst_outputs", 64'({STB_O, WE_O, ADR_O, SEL_O}), 64'd0);
        chk("mid_rst_rdy", 64'({RDY_request_put, RDY_response_get}), 64'b10);
        RST_N = 1'b1;
        auto_ack = 1'b1;
        repeat (10) tick();
        chk("post_rst_no_rsp", 64'({CYC_O, RDY_response_get}), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
